// File: rtl/aes_encrypt_core_if.sv
// ---------------------------------------------------------------------------
// aes_encrypt_core_if
// Bundles the request/result and round-key fetch signals of the AES encrypt
// core.
//   start        : request to encrypt one block
//   key_len      : 01 = AES-128, 10 = AES-192, 11 = AES-256, 00 = invalid
//   plaintext    : 128-bit input block, byte 0 in [127:120]
//   ready        : level flag, ciphertext holds a completed result
//   ciphertext   : 128-bit result register
//   subkey       : round key matching subkey_addr
//   subkey_valid : subkey is valid for subkey_addr this cycle
//   subkey_addr  : round-key index requested by the core
// The master side is the requester that also owns the subkey store.
// ---------------------------------------------------------------------------
interface aes_encrypt_core_if;
    logic         start;
    logic [1:0]   key_len;
    logic [127:0] plaintext;
    logic         ready;
    logic [127:0] ciphertext;
    logic [127:0] subkey;
    logic         subkey_valid;
    logic [3:0]   subkey_addr;

    modport master (
        output start, key_len, plaintext, subkey, subkey_valid,
        input  ready, ciphertext, subkey_addr
    );

    modport slave (
        input  start, key_len, plaintext, subkey, subkey_valid,
        output ready, ciphertext, subkey_addr
    );
endinterface

// File: rtl/aes_encrypt_core.sv
// ---------------------------------------------------------------------------
// aes_encrypt_core
// Iterative AES-128/192/256 encryption, one round per clock. Round keys are
// fetched in ascending order 0..Nr over subkey_addr/subkey_valid; a low
// subkey_valid stalls the engine with every register held.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : aes_encrypt_core_if.slave (request, result and key fetch)
// ---------------------------------------------------------------------------
module aes_encrypt_core #(
    parameter int NR_MAX = 14
) (
    input  logic               clk,
    input  logic               reset,
    aes_encrypt_core_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_INIT  = 2'd1,
        ST_ROUND = 2'd2
    } fsm_e;

    // Key lengths whose round count exceeds this build limit are refused.
    localparam logic [3:0] NR_CAP_C = 4'(NR_MAX);

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] aa;
        acc = 8'h00;
        aa  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ aa;
            else      acc = acc;
            aa = xtime(aa);
        end
        return acc;
    endfunction

    // S-box evaluated algebraically: inverse as a^254, then the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] x2, x4, x8, x16, x32, x64, x128, inv;
        x2   = gf_mul(a, a);
        x4   = gf_mul(x2, x2);
        x8   = gf_mul(x4, x4);
        x16  = gf_mul(x8, x8);
        x32  = gf_mul(x16, x16);
        x64  = gf_mul(x32, x32);
        x128 = gf_mul(x64, x64);
        inv  = gf_mul(gf_mul(gf_mul(x2, x4), gf_mul(x8, x16)),
                      gf_mul(gf_mul(x32, x64), x128));
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = 128'h0;
        for (int n = 0; n < 16; n++) o[127 - 8*n -: 8] = sbox(s[127 - 8*n -: 8]);
        return o;
    endfunction

    // Byte n sits at row n%4, column n/4; row r rotates left by r columns.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = 128'h0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                o[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c + r) % 4)) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = 128'h0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            o[127 - 32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119 - 32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111 - 32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103 - 32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    function automatic logic [3:0] key_nr(input logic [1:0] kl);
        case (kl)
            2'b01:   return 4'd10;
            2'b10:   return 4'd12;
            2'b11:   return 4'd14;
            default: return 4'd0;
        endcase
    endfunction

    fsm_e         fsm_q, fsm_d;
    logic [127:0] state_q, state_d;
    logic [127:0] ciphertext_q, ciphertext_d;
    logic [3:0]   nr_q, nr_d;
    logic [3:0]   subkey_addr_q, subkey_addr_d;
    logic         ready_q, ready_d;

    logic [3:0]   req_nr_s;
    logic         accept_s;
    logic [127:0] sb_sr_s;
    logic [127:0] round_s;
    logic [127:0] final_s;

    // Round datapath and start qualification
    always_comb begin
        sb_sr_s  = shift_rows(sub_bytes(state_q));
        round_s  = mix_columns(sb_sr_s) ^ bus.subkey;
        final_s  = sb_sr_s ^ bus.subkey;
        req_nr_s = key_nr(bus.key_len);
        accept_s = bus.start && (bus.key_len != 2'b00) && (req_nr_s <= NR_CAP_C);
    end

    // Next-state logic; subkey_addr doubles as the round counter
    always_comb begin
        fsm_d         = fsm_q;
        state_d       = state_q;
        ciphertext_d  = ciphertext_q;
        nr_d          = nr_q;
        subkey_addr_d = subkey_addr_q;
        ready_d       = ready_q;
        case (fsm_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d       = bus.plaintext;
                    nr_d          = req_nr_s;
                    subkey_addr_d = 4'd0;
                    ready_d       = 1'b0;
                    fsm_d         = ST_INIT;
                end else begin
                    fsm_d = ST_IDLE;
                end
            end
            ST_INIT: begin
                if (bus.subkey_valid) begin
                    state_d       = state_q ^ bus.subkey;
                    subkey_addr_d = 4'd1;
                    fsm_d         = ST_ROUND;
                end else begin
                    fsm_d = ST_INIT;
                end
            end
            ST_ROUND: begin
                if (bus.subkey_valid) begin
                    if (subkey_addr_q == nr_q) begin
                        // Last round skips MixColumns and publishes the block.
                        ciphertext_d  = final_s;
                        ready_d       = 1'b1;
                        subkey_addr_d = 4'd0;
                        fsm_d         = ST_IDLE;
                    end else begin
                        state_d       = round_s;
                        subkey_addr_d = subkey_addr_q + 4'd1;
                    end
                end else begin
                    fsm_d = ST_ROUND;
                end
            end
            default: begin
                fsm_d = ST_IDLE;
            end
        endcase
    end

    // State register, round counter and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fsm_q         <= ST_IDLE;
            state_q       <= 128'h0;
            ciphertext_q  <= 128'h0;
            nr_q          <= 4'd0;
            subkey_addr_q <= 4'd0;
            ready_q       <= 1'b0;
        end else begin
            fsm_q         <= fsm_d;
            state_q       <= state_d;
            ciphertext_q  <= ciphertext_d;
            nr_q          <= nr_d;
            subkey_addr_q <= subkey_addr_d;
            ready_q       <= ready_d;
        end
    end

    assign bus.ready       = ready_q;
    assign bus.ciphertext  = ciphertext_q;
    assign bus.subkey_addr = subkey_addr_q;

endmodule

// File: tb/tb_aes_encrypt_core.sv
// ---------------------------------------------------------------------------
// tb_aes_encrypt_core
// Self-checking bench: FIPS-197 known answers, a table-driven reference
// model with its own key schedule, random subkey_valid gaps, protocol
// robustness cases and an asynchronous reset in the middle of a block.
// ---------------------------------------------------------------------------
module tb_aes_encrypt_core;

    logic clk;
    logic reset;
    aes_encrypt_core_if bus ();

    aes_encrypt_core #(.NR_MAX(14)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [255:0] KEY_C = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;

    int           n_tests;
    int           n_fail;
    logic [7:0]   sbox_t [0:255];
    logic [127:0] rk [0:15];
    logic [127:0] kat [1:3];
    logic [127:0] junk;

    // Key store: real round key when valid, garbage otherwise.
    assign bus.subkey = bus.subkey_valid ? rk[bus.subkey_addr] : junk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] mul2(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // S-box table via the generator-3 walk over GF(2^8).
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sbox_t[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox_t[0] = 8'h63;
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
    endfunction

    task automatic key_expand(input logic [255:0] key, input logic [1:0] kl);
        logic [31:0] w [0:59];
        logic [31:0] tmp;
        logic [7:0]  rcon;
        int nk, nr;
        nk   = (kl == 2'b01) ? 4 : (kl == 2'b10) ? 6 : 8;
        nr   = nk + 6;
        rcon = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < 4*(nr + 1); i++) begin
            tmp = w[i-1];
            if (i % nk == 0) begin
                tmp  = sub_word({tmp[23:0], tmp[31:24]}) ^ {rcon, 24'h0};
                rcon = mul2(rcon);
            end else if (nk == 8 && i % nk == 4) begin
                tmp = sub_word(tmp);
            end
            w[i] = w[i-nk] ^ tmp;
        end
        for (int r = 0; r <= nr; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] ref_encrypt(input logic [127:0] pt, input int nr);
        logic [7:0]   s [4][4];
        logic [7:0]   t [4][4];
        logic [127:0] o;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                s[r][c] = pt[127 - 8*(4*c + r) -: 8] ^ rk[0][127 - 8*(4*c + r) -: 8];
        for (int rnd = 1; rnd <= nr; rnd++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    t[r][c] = sbox_t[s[r][(c + r) % 4]];
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) begin
                    if (rnd < nr)
                        s[r][c] = mul2(t[r][c]) ^ mul2(t[(r+1)%4][c]) ^ t[(r+1)%4][c]
                                ^ t[(r+2)%4][c] ^ t[(r+3)%4][c];
                    else
                        s[r][c] = t[r][c];
                end
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    s[r][c] = s[r][c] ^ rk[rnd][127 - 8*(4*c + r) -: 8];
        end
        o = 128'h0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[127 - 8*(4*c + r) -: 8] = s[r][c];
        return o;
    endfunction

    // One block: start, then feed keys with the given valid duty (percent).
    // poke re-asserts start with key_len=11 in the middle of the block.
    task automatic run_block(input logic [1:0] kl, input logic [127:0] pt, input int duty,
                             input bit poke, output logic [127:0] ct,
                             output int lat, output int stalls);
        int exp_addr;
        bit done;
        @(negedge clk);
        bus.start     = 1'b1;
        bus.key_len   = kl;
        bus.plaintext = pt;
        @(posedge clk);
        #1;
        check_eq("rdy_clr", 128'(bus.ready), 128'd0);
        @(negedge clk);
        bus.start     = 1'b0;
        bus.key_len   = 2'($urandom_range(3, 0));
        bus.plaintext = {$urandom, $urandom, $urandom, $urandom};
        lat = 0; stalls = 0; done = 1'b0; exp_addr = 0;
        while (!done && lat < 400) begin
            junk = {$urandom, $urandom, $urandom, $urandom};
            bus.subkey_valid = ($urandom_range(99, 0) < duty);
            if (!bus.subkey_valid) stalls++;
            if (poke && lat == 3) begin
                bus.start     = 1'b1;
                bus.key_len   = 2'b11;
                bus.plaintext = {$urandom, $urandom, $urandom, $urandom};
            end else begin
                bus.start = 1'b0;
            end
            check_eq("addr_seq", 128'(bus.subkey_addr), 128'(exp_addr));
            @(posedge clk);
            #1;
            lat++;
            if (bus.subkey_valid) exp_addr++;
            if (bus.ready) done = 1'b1;
            else @(negedge clk);
        end
        bus.start = 1'b0;
        if (!done) check_eq("timeout", 128'd0, 128'd1);
        check_eq("addr_done", 128'(bus.subkey_addr), 128'd0);
        ct = bus.ciphertext;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] ct, prev, pt;
        logic [255:0] key;
        logic [1:0]   kl;
        int lat, stalls, cnt;

        n_tests = 0;
        n_fail  = 0;
        build_sbox();
        for (int i = 0; i < 16; i++) rk[i] = 128'h0;
        kat[1] = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        kat[2] = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
        kat[3] = 128'h8ea2b7ca516745bfeafc49904b496089;
        junk = 128'h0;
        reset = 1'b0;
        bus.start = 1'b0;
        bus.key_len = 2'b00;
        bus.plaintext = 128'h0;
        bus.subkey_valid = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ready", 128'(bus.ready), 128'd0);
        check_eq("rst_ct", bus.ciphertext, 128'd0);
        check_eq("rst_addr", 128'(bus.subkey_addr), 128'd0);
        @(negedge clk);
        reset = 1'b1;

        // Known answers with subkey_valid held high.
        for (int k = 1; k <= 3; k++) begin
            key_expand(KEY_C, 2'(k));
            run_block(2'(k), PT_C, 100, 1'b0, ct, lat, stalls);
            check_eq("kat_ct", ct, kat[k]);
            check_eq("model_ct", ct, ref_encrypt(PT_C, 8 + 2*k));
            check_eq("kat_lat", 128'(lat), 128'(9 + 2*k));
        end

        // Random valid gaps on the AES-128 vector.
        key_expand(KEY_C, 2'b01);
        for (int i = 0; i < 3; i++) begin
            run_block(2'b01, PT_C, 50, 1'b0, ct, lat, stalls);
            check_eq("gap_ct", ct, kat[1]);
            check_eq("gap_lat", 128'(lat), 128'(11 + stalls));
        end

        // start with key_len=00 is ignored.
        prev = bus.ciphertext;
        @(negedge clk);
        bus.start = 1'b1;
        bus.key_len = 2'b00;
        bus.plaintext = {$urandom, $urandom, $urandom, $urandom};
        bus.subkey_valid = 1'b1;
        @(posedge clk);
        #1;
        check_eq("kl0_ready", 128'(bus.ready), 128'd1);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("kl0_addr", 128'(bus.subkey_addr), 128'd0);
        check_eq("kl0_ct", bus.ciphertext, prev);
        check_eq("kl0_ready2", 128'(bus.ready), 128'd1);

        // Mid-operation start with key_len=11 is ignored.
        run_block(2'b01, PT_C, 100, 1'b1, ct, lat, stalls);
        check_eq("poke_ct", ct, kat[1]);
        check_eq("poke_lat", 128'(lat), 128'd11);

        // Back-to-back random blocks; rdy_clr inside run_block covers the clear.
        for (int i = 0; i < 4; i++) begin
            key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            kl  = 2'($urandom_range(3, 1));
            pt  = {$urandom, $urandom, $urandom, $urandom};
            key_expand(key, kl);
            run_block(kl, pt, 70, 1'b0, ct, lat, stalls);
            check_eq("rand_ct", ct, ref_encrypt(pt, 8 + 2*int'(kl)));
            check_eq("rand_lat", 128'(lat), 128'(9 + 2*int'(kl) + stalls));
        end

        // Asynchronous reset at round 5 of an AES-256 block.
        key_expand(KEY_C, 2'b11);
        @(negedge clk);
        bus.start = 1'b1;
        bus.key_len = 2'b11;
        bus.plaintext = PT_C;
        bus.subkey_valid = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cnt = 0;
        while (bus.subkey_addr != 4'd5 && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        check_eq("rst_reach5", 128'(bus.subkey_addr), 128'd5);
        #2;
        reset = 1'b0;
        #1;
        check_eq("arst_ready", 128'(bus.ready), 128'd0);
        check_eq("arst_ct", bus.ciphertext, 128'd0);
        check_eq("arst_addr", 128'(bus.subkey_addr), 128'd0);
        @(negedge clk);
        reset = 1'b1;
        key_expand(KEY_C, 2'b01);
        run_block(2'b01, PT_C, 100, 1'b0, ct, lat, stalls);
        check_eq("post_rst_ct", ct, kat[1]);
        check_eq("post_rst_lat", 128'(lat), 128'd11);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_encrypt_core.md
Name: aes_encrypt_core

Overview:
Iterative AES-128/192/256 encryption engine, one round per clock. Forward counterpart of the decrypt core: it fetches round keys from the shared subkey store in ascending order (0..Nr) over the same address/valid interface. It sits beside the decrypt core under the AES top level. It accepts one plaintext block per start and returns the ciphertext with a level ready flag.

Parameters:
NR_MAX, 14, maximum round count supported; sets the subkey_addr range (4 bits).

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset)
start  input  1  request to encrypt; sampled only in IDLE
key_len  input  2  01 = AES-128 (Nr=10), 10 = AES-192 (Nr=12), 11 = AES-256 (Nr=14), 00 = invalid
ready  output  1  high when ciphertext holds a completed result
plaintext  input  128  block to encrypt; byte 0 = [127:120], column-major per FIPS-197
ciphertext  output  128  result register
subkey  input  128  round key for the current subkey_addr
subkey_valid  input  1  subkey corresponds to subkey_addr this cycle
subkey_addr  output  4  round-key index requested

Behaviour:
- Reset (reset=0, asynchronous):
  - ready=0, ciphertext=0, subkey_addr=0.
  - Internal state register = 0, round counter = 0, FSM = IDLE.
  - Reset asserted mid-operation aborts the operation; no partial result is ever visible.
- FSM states: IDLE, INIT, ROUND.
- IDLE:
  - start=1 and key_len!=00: latch plaintext into the state register, latch Nr from key_len, subkey_addr<=0, ready<=0, go to INIT.
  - key_len=00 with start=1: ignored; stay in IDLE, ready unchanged.
- INIT:
  - Waits for subkey_valid.
  - On a valid edge: state <= state XOR subkey (round 0), subkey_addr<=1, go to ROUND.
- ROUND:
  - Each edge with subkey_valid=1 applies one round and increments subkey_addr.
  - subkey_addr < Nr: state <= MixColumns(ShiftRows(SubBytes(state))) XOR subkey.
  - subkey_addr == Nr (final round, no MixColumns): ciphertext <= ShiftRows(SubBytes(state)) XOR subkey, ready<=1, subkey_addr<=0, go to IDLE.
- Stall: subkey_valid=0 in INIT or ROUND holds all registers and subkey_addr unchanged, for any number of cycles.
- Latency: with subkey_valid tied high, ready rises Nr+1 clocks after the start edge (11 / 13 / 15 for 128 / 192 / 256).
- ready is a level signal:
  - Stays high until the next accepted start, which clears it on that same edge.
  - ciphertext holds its value until the next completion.
- start while in INIT or ROUND: ignored. key_len and plaintext changes after acceptance: ignored (latched).
- Back-to-back: start may be asserted on the cycle after completion (FSM already in IDLE). Throughput is Nr+2 cycles per block.
- ciphertext is never updated with intermediate round values.
- Arithmetic:
  - GF(2^8) MixColumns uses xtime with polynomial 0x11B.
  - S-box per FIPS-197.
  - The team's forward round primitives are used.

Test Plan:
- AES-128: key 000102…0f (subkeys from bench key-schedule model), plaintext 00112233445566778899aabbccddeeff, subkey_valid=1 -> ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a; ready rises 11 cycles after start; subkey_addr sequence 0,1…10.
- AES-192: key 000102…17, same plaintext -> dda97ca4864cdfe06eaf70a0ec0d7191, ready after 13 cycles.
- AES-256: key 000102…1f, same plaintext -> 8ea2b7ca516745bfeafc49904b496089, ready after 15 cycles.
- Random subkey_valid gaps (about 50% duty) on the AES-128 vector:
  - Same ciphertext results.
  - subkey_addr never advances while valid=0.
  - Latency = 11 + number of stall cycles.
- Protocol robustness:
  - start with key_len=00: no state change.
  - start pulsed mid-operation, with key_len changed to 11: ignored, original AES-128 result returned.
  - Back-to-back blocks: ready clears on the second start edge.
- Reset: assert reset=0 at round 5 -> all outputs 0 immediately, with no clock edge required. Release, then restart -> correct ciphertext.
